// File: rtl/pipe_ctrl_v2.sv
// Pipeline controller: masked per-stage stall merge, exception/eret flush sequencing, stall counters, watchdog.
// Flush rises one cycle after an unblocked redirect; stall bus is combinational and gated off by reset/flush.
module pipe_ctrl_v2 #(
    parameter int                        STAGES     = 7,
    parameter int                        NREQ       = 8,
    parameter logic [NREQ*STAGES-1:0]    REQ_MASK   = '1,
    parameter logic [NREQ-1:0]           BLOCK_MASK = '1,
    parameter int                        FLUSH_LEN  = 1,
    parameter int                        TIMEOUT    = 1024,
    parameter int                        CNT_WD     = 32,
    localparam int                       SELW       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     stallreq,
    input  logic                excp_valid,
    input  logic [31:0]         excp_pc,
    input  logic [SELW-1:0]     rd_sel,
    output logic                flush,
    output logic [31:0]         new_pc,
    output logic [STAGES-1:0]   stall,
    output logic                pend,
    output logic                excp_drop,
    output logic                stall_timeout,
    output logic [CNT_WD-1:0]   rd_data
);

    localparam int WDW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_PEND, S_FLUSH} state_t;

    state_t             state_q;
    logic [3:0]         fcnt_q;
    logic [31:0]        pc_q;
    logic [31:0]        cap_pc_q;
    logic               cap_vld_q;
    logic               flush_q;
    logic               pend_q;
    logic               drop_q;
    logic [31:0]        new_pc_q;
    logic               blocked;
    logic [STAGES-1:0]  stall_mrg;
    logic [CNT_WD-1:0]  cnt_q [NREQ];
    logic [WDW-1:0]     wd_q;
    logic [WDW-1:0]     wd_d;
    logic               to_q;

    assign blocked = |(stallreq & BLOCK_MASK);

    always_comb begin
        stall_mrg = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (stallreq[i]) begin
                stall_mrg = stall_mrg | REQ_MASK[i*STAGES +: STAGES];
            end
        end
        if (rst || flush_q) begin
            stall_mrg = '0;
        end
    end

    // The oldest redirect always wins: a second one arriving while one is queued is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            fcnt_q    <= '0;
            pc_q      <= '0;
            cap_pc_q  <= '0;
            cap_vld_q <= 1'b0;
            flush_q   <= 1'b0;
            pend_q    <= 1'b0;
            drop_q    <= 1'b0;
            new_pc_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (excp_valid) begin
                        pc_q <= excp_pc;
                        if (blocked) begin
                            state_q <= S_PEND;
                            pend_q  <= 1'b1;
                        end else begin
                            state_q  <= S_FLUSH;
                            flush_q  <= 1'b1;
                            new_pc_q <= excp_pc;
                            fcnt_q   <= 4'(FLUSH_LEN);
                        end
                    end
                end
                S_PEND: begin
                    if (excp_valid) begin
                        drop_q <= 1'b1;
                    end
                    if (!blocked) begin
                        state_q  <= S_FLUSH;
                        pend_q   <= 1'b0;
                        flush_q  <= 1'b1;
                        new_pc_q <= pc_q;
                        fcnt_q   <= 4'(FLUSH_LEN);
                    end
                end
                S_FLUSH: begin
                    if (excp_valid && cap_vld_q) begin
                        drop_q <= 1'b1;
                    end
                    if (fcnt_q <= 4'd1) begin
                        flush_q  <= 1'b0;
                        new_pc_q <= '0;
                        if (cap_vld_q) begin
                            state_q   <= S_PEND;
                            pend_q    <= 1'b1;
                            pc_q      <= cap_pc_q;
                            cap_vld_q <= 1'b0;
                        end else if (excp_valid) begin
                            state_q <= S_PEND;
                            pend_q  <= 1'b1;
                            pc_q    <= excp_pc;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else begin
                        fcnt_q <= fcnt_q - 4'd1;
                        if (excp_valid && !cap_vld_q) begin
                            cap_vld_q <= 1'b1;
                            cap_pc_q  <= excp_pc;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    flush_q <= 1'b0;
                    pend_q  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (stallreq[i] && !flush_q && (cnt_q[i] != '1)) begin
                    cnt_q[i] <= cnt_q[i] + CNT_WD'(1);
                end
            end
        end
    end

    always_comb begin
        wd_d = '0;
        if (|stall_mrg) begin
            wd_d = (wd_q == WDW'(TIMEOUT)) ? wd_q : wd_q + WDW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q <= '0;
            to_q <= 1'b0;
        end else begin
            wd_q <= wd_d;
            if (wd_d == WDW'(TIMEOUT)) begin
                to_q <= 1'b1;
            end
        end
    end

    assign flush         = flush_q;
    assign new_pc        = new_pc_q;
    assign stall         = stall_mrg;
    assign pend          = pend_q;
    assign excp_drop     = drop_q;
    assign stall_timeout = to_q;
    assign rd_data       = (int'(rd_sel) < NREQ) ? cnt_q[rd_sel] : '0;

endmodule

// File: tb/tb_pipe_ctrl_v2.sv
// Directed bench for pipe_ctrl_v2: dut_a (FLUSH_LEN=1, CNT_WD=4, TIMEOUT=8) and dut_b (FLUSH_LEN=3) share stimulus.
// Sources: 0=cache (blocking, all stages), 1=load (3'b101), 2=fifo (stage 0), 3=TLB (blocking, all stages).
module tb_pipe_ctrl_v2;

    localparam logic [55:0] RM = {28'b0, 7'h7F, 7'b0000001, 7'b0000101, 7'h7F};
    localparam logic [7:0]  BM = 8'b0000_1001;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  stallreq;
    logic        excp_valid;
    logic [31:0] excp_pc;
    logic [2:0]  rd_sel;

    logic        flush_a, pend_a, drop_a, to_a;
    logic [31:0] new_pc_a;
    logic [6:0]  stall_a;
    logic [3:0]  rd_data_a;
    logic        flush_b, pend_b, drop_b, to_b;
    logic [31:0] new_pc_b;
    logic [6:0]  stall_b;
    logic [31:0] rd_data_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pipe_ctrl_v2 #(.STAGES(7), .NREQ(8), .REQ_MASK(RM), .BLOCK_MASK(BM),
                   .FLUSH_LEN(1), .TIMEOUT(8), .CNT_WD(4)) dut_a (
        .clk(clk), .rst(rst), .stallreq(stallreq), .excp_valid(excp_valid),
        .excp_pc(excp_pc), .rd_sel(rd_sel), .flush(flush_a), .new_pc(new_pc_a),
        .stall(stall_a), .pend(pend_a), .excp_drop(drop_a),
        .stall_timeout(to_a), .rd_data(rd_data_a));

    pipe_ctrl_v2 #(.STAGES(7), .NREQ(8), .REQ_MASK(RM), .BLOCK_MASK(BM),
                   .FLUSH_LEN(3), .TIMEOUT(1024), .CNT_WD(32)) dut_b (
        .clk(clk), .rst(rst), .stallreq(stallreq), .excp_valid(excp_valid),
        .excp_pc(excp_pc), .rd_sel(rd_sel), .flush(flush_b), .new_pc(new_pc_b),
        .stall(stall_b), .pend(pend_b), .excp_drop(drop_b),
        .stall_timeout(to_b), .rd_data(rd_data_b));

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; stallreq = '0; excp_valid = 1'b0; excp_pc = '0; rd_sel = '0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; stallreq = 8'hFF; excp_valid = 1'b0; excp_pc = '0; rd_sel = '0;
        #1;
        n_cmp++; if (stall_a !== 7'h00) begin n_bad++; $display("FAIL rst_stall0: got %b want 0000000", stall_a); end
        cyc();
        n_cmp++; if (stall_a !== 7'h00) begin n_bad++; $display("FAIL rst_stall1: got %b want 0000000", stall_a); end
        cyc();
        rst = 1'b0; stallreq = '0;
        #1;
        n_cmp++; if (flush_a !== 1'b0) begin n_bad++; $display("FAIL rst_flush: got %b want 0", flush_a); end
        n_cmp++; if (new_pc_a !== 32'h0) begin n_bad++; $display("FAIL rst_new_pc: got %h want 0", new_pc_a); end
        n_cmp++; if (pend_a !== 1'b0) begin n_bad++; $display("FAIL rst_pend: got %b want 0", pend_a); end
        n_cmp++; if (drop_a !== 1'b0) begin n_bad++; $display("FAIL rst_drop: got %b want 0", drop_a); end
        n_cmp++; if (to_a !== 1'b0) begin n_bad++; $display("FAIL rst_timeout: got %b want 0", to_a); end
        n_cmp++; if (rd_data_a !== 4'h0) begin n_bad++; $display("FAIL rst_cnt0: got %0d want 0", rd_data_a); end
        n_cmp++; if (flush_b !== 1'b0) begin n_bad++; $display("FAIL rst_flush_b: got %b want 0", flush_b); end
    endtask

    task automatic test_unblocked();
        cyc();
        stallreq = 8'b0000_0010; excp_valid = 1'b1; excp_pc = 32'hBFC00380;
        #1;
        n_cmp++; if (flush_a !== 1'b0) begin n_bad++; $display("FAIL unblk_flush_n: got %b want 0", flush_a); end
        n_cmp++; if (stall_a !== 7'b0000101) begin n_bad++; $display("FAIL unblk_stall_n: got %b want 0000101", stall_a); end
        cyc();
        excp_valid = 1'b0; excp_pc = '0;
        #1;
        n_cmp++; if (flush_a !== 1'b1) begin n_bad++; $display("FAIL unblk_flush_n1: got %b want 1", flush_a); end
        n_cmp++; if (new_pc_a !== 32'hBFC00380) begin n_bad++; $display("FAIL unblk_new_pc: got %h want bfc00380", new_pc_a); end
        n_cmp++; if (stall_a !== 7'h00) begin n_bad++; $display("FAIL unblk_stall_gated: got %b want 0000000", stall_a); end
        cyc();
        #1;
        n_cmp++; if (flush_a !== 1'b0) begin n_bad++; $display("FAIL unblk_flush_n2: got %b want 0", flush_a); end
        n_cmp++; if (new_pc_a !== 32'h0) begin n_bad++; $display("FAIL unblk_new_pc_n2: got %h want 0", new_pc_a); end
        n_cmp++; if (stall_a !== 7'b0000101) begin n_bad++; $display("FAIL unblk_stall_n2: got %b want 0000101", stall_a); end
        stallreq = '0;
    endtask

    task automatic test_blocked();
        do_reset();
        cyc();
        stallreq = 8'b0000_0001; excp_valid = 1'b1; excp_pc = 32'h80000180;
        #1;
        n_cmp++; if (stall_a !== 7'h7F) begin n_bad++; $display("FAIL blk_stall_c1: got %b want 1111111", stall_a); end
        n_cmp++; if (pend_a !== 1'b0) begin n_bad++; $display("FAIL blk_pend_c1: got %b want 0", pend_a); end
        for (int c = 2; c <= 5; c++) begin
            cyc();
            excp_valid = 1'b0; excp_pc = '0;
            #1;
            n_cmp++; if (pend_a !== 1'b1) begin n_bad++; $display("FAIL blk_pend_c%0d: got %b want 1", c, pend_a); end
            n_cmp++; if (flush_a !== 1'b0) begin n_bad++; $display("FAIL blk_flush_c%0d: got %b want 0", c, flush_a); end
            n_cmp++; if (stall_a !== 7'h7F) begin n_bad++; $display("FAIL blk_stall_c%0d: got %b want 1111111", c, stall_a); end
        end
        cyc();
        stallreq = 8'b0000_0010;
        #1;
        n_cmp++; if (pend_a !== 1'b1) begin n_bad++; $display("FAIL blk_pend_c6: got %b want 1", pend_a); end
        n_cmp++; if (flush_a !== 1'b0) begin n_bad++; $display("FAIL blk_flush_c6: got %b want 0", flush_a); end
        n_cmp++; if (stall_a !== 7'b0000101) begin n_bad++; $display("FAIL blk_stall_c6: got %b want 0000101", stall_a); end
        cyc();
        #1;
        n_cmp++; if (flush_a !== 1'b1) begin n_bad++; $display("FAIL blk_flush_c7: got %b want 1", flush_a); end
        n_cmp++; if (pend_a !== 1'b0) begin n_bad++; $display("FAIL blk_pend_c7: got %b want 0", pend_a); end
        n_cmp++; if (new_pc_a !== 32'h80000180) begin n_bad++; $display("FAIL blk_new_pc_c7: got %h want 80000180", new_pc_a); end
        n_cmp++; if (stall_a !== 7'h00) begin n_bad++; $display("FAIL blk_stall_c7: got %b want 0000000", stall_a); end
        cyc();
        #1;
        n_cmp++; if (flush_a !== 1'b0) begin n_bad++; $display("FAIL blk_flush_c8: got %b want 0", flush_a); end
        n_cmp++; if (stall_a !== 7'b0000101) begin n_bad++; $display("FAIL blk_stall_c8: got %b want 0000101", stall_a); end
        n_cmp++; if (drop_a !== 1'b0) begin n_bad++; $display("FAIL blk_drop: got %b want 0", drop_a); end
        stallreq = '0;
    endtask

    task automatic test_mask_merge();
        logic [7:0] req [5];
        logic [6:0] exp [5];
        do_reset();
        req[0] = 8'b0000_0110; exp[0] = 7'b0000101;
        req[1] = 8'b0000_0010; exp[1] = 7'b0000101;
        req[2] = 8'b0000_0100; exp[2] = 7'b0000001;
        req[3] = 8'b0000_1000; exp[3] = 7'b1111111;
        req[4] = 8'b0000_0000; exp[4] = 7'b0000000;
        for (int v = 0; v < 5; v++) begin
            stallreq = req[v];
            #1;
            n_cmp++; if (stall_a !== exp[v]) begin n_bad++; $display("FAIL mask_v%0d: got %b want %b", v, stall_a, exp[v]); end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        cyc();
        excp_valid = 1'b1; excp_pc = 32'h11110000;
        #1;
        n_cmp++; if (flush_b !== 1'b0) begin n_bad++; $display("FAIL b2b_flush_n: got %b want 0", flush_b); end
        cyc();
        excp_pc = 32'h22220000;
        #1;
        n_cmp++; if (flush_b !== 1'b1) begin n_bad++; $display("FAIL b2b_flush_n1: got %b want 1", flush_b); end
        n_cmp++; if (new_pc_b !== 32'h11110000) begin n_bad++; $display("FAIL b2b_pc_n1: got %h want 11110000", new_pc_b); end
        n_cmp++; if (new_pc_a !== 32'h11110000) begin n_bad++; $display("FAIL b2b_a_pc_n1: got %h want 11110000", new_pc_a); end
        cyc();
        excp_pc = 32'h33330000;
        #1;
        n_cmp++; if (new_pc_b !== 32'h11110000) begin n_bad++; $display("FAIL b2b_pc_n2: got %h want 11110000", new_pc_b); end
        n_cmp++; if (drop_b !== 1'b0) begin n_bad++; $display("FAIL b2b_drop_n2: got %b want 0", drop_b); end
        n_cmp++; if (pend_a !== 1'b1) begin n_bad++; $display("FAIL b2b_a_pend_n2: got %b want 1", pend_a); end
        cyc();
        excp_valid = 1'b0; excp_pc = '0;
        #1;
        n_cmp++; if (flush_b !== 1'b1) begin n_bad++; $display("FAIL b2b_flush_n3: got %b want 1", flush_b); end
        n_cmp++; if (new_pc_b !== 32'h11110000) begin n_bad++; $display("FAIL b2b_pc_n3: got %h want 11110000", new_pc_b); end
        n_cmp++; if (drop_b !== 1'b1) begin n_bad++; $display("FAIL b2b_drop_n3: got %b want 1", drop_b); end
        n_cmp++; if (new_pc_a !== 32'h22220000) begin n_bad++; $display("FAIL b2b_a_pc_n3: got %h want 22220000", new_pc_a); end
        n_cmp++; if (drop_a !== 1'b1) begin n_bad++; $display("FAIL b2b_a_drop_n3: got %b want 1", drop_a); end
        cyc();
        #1;
        n_cmp++; if (flush_b !== 1'b0) begin n_bad++; $display("FAIL b2b_flush_n4: got %b want 0", flush_b); end
        n_cmp++; if (pend_b !== 1'b1) begin n_bad++; $display("FAIL b2b_pend_n4: got %b want 1", pend_b); end
        for (int c = 5; c <= 7; c++) begin
            cyc();
            #1;
            n_cmp++; if (flush_b !== 1'b1) begin n_bad++; $display("FAIL b2b_flush_n%0d: got %b want 1", c, flush_b); end
            n_cmp++; if (new_pc_b !== 32'h22220000) begin n_bad++; $display("FAIL b2b_pc_n%0d: got %h want 22220000", c, new_pc_b); end
        end
        cyc();
        #1;
        n_cmp++; if (flush_b !== 1'b0) begin n_bad++; $display("FAIL b2b_flush_n8: got %b want 0", flush_b); end
        n_cmp++; if (pend_b !== 1'b0) begin n_bad++; $display("FAIL b2b_pend_n8: got %b want 0", pend_b); end
        n_cmp++; if (drop_b !== 1'b1) begin n_bad++; $display("FAIL b2b_drop_sticky: got %b want 1", drop_b); end
    endtask

    task automatic test_watchdog();
        do_reset();
        for (int c = 0; c < 6; c++) begin
            cyc();
            stallreq = 8'b0000_0100;
        end
        cyc();
        stallreq = '0;
        #1;
        n_cmp++; if (to_a !== 1'b0) begin n_bad++; $display("FAIL wd_gap: got %b want 0", to_a); end
        for (int k = 1; k <= 8; k++) begin
            cyc();
            stallreq = 8'b0000_0100;
            #1;
            n_cmp++; if (to_a !== 1'b0) begin n_bad++; $display("FAIL wd_early_k%0d: got %b want 0", k, to_a); end
        end
        cyc();
        stallreq = '0;
        #1;
        n_cmp++; if (to_a !== 1'b1) begin n_bad++; $display("FAIL wd_trip: got %b want 1", to_a); end
        n_cmp++; if (to_b !== 1'b0) begin n_bad++; $display("FAIL wd_b_quiet: got %b want 0", to_b); end
        cyc();
        #1;
        n_cmp++; if (to_a !== 1'b1) begin n_bad++; $display("FAIL wd_sticky: got %b want 1", to_a); end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        n_cmp++; if (to_a !== 1'b0) begin n_bad++; $display("FAIL wd_rst_clear: got %b want 0", to_a); end
    endtask

    task automatic test_counters();
        logic [3:0]  ea;
        logic [31:0] eb;
        do_reset();
        rd_sel = 3'd2;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            stallreq = 8'b0000_0100;
            #1;
            ea = (k - 1 > 15) ? 4'd15 : 4'(k - 1);
            eb = 32'(k - 1);
            n_cmp++; if (rd_data_a !== ea) begin n_bad++; $display("FAIL cnt_a_k%0d: got %0d want %0d", k, rd_data_a, ea); end
            n_cmp++; if (rd_data_b !== eb) begin n_bad++; $display("FAIL cnt_b_k%0d: got %0d want %0d", k, rd_data_b, eb); end
        end
        cyc();
        stallreq = '0;
        #1;
        n_cmp++; if (rd_data_a !== 4'd15) begin n_bad++; $display("FAIL cnt_a_sat: got %0d want 15", rd_data_a); end
        n_cmp++; if (rd_data_b !== 32'd20) begin n_bad++; $display("FAIL cnt_b_final: got %0d want 20", rd_data_b); end
        for (int s = 0; s < 8; s++) begin
            if (s != 2) begin
                rd_sel = 3'(s);
                #1;
                n_cmp++; if (rd_data_a !== 4'd0) begin n_bad++; $display("FAIL cnt_other_%0d: got %0d want 0", s, rd_data_a); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_unblocked();
        test_blocked();
        test_mask_merge();
        test_back_to_back();
        test_watchdog();
        test_counters();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl_v2.md
# pipe_ctrl_v2

Parametrised pipeline controller for the CPU core: merges per-source stall requests into a per-stage stall bus through configurable masks, and sequences exception/eret redirects into multi-cycle flush pulses. A redirect raised while a blocking source (cache, TLB refill) is busy is held pending and issued once that source releases. It sits between the stage stall/exception sources and every pipeline register, and replaces the fixed 7-stage combinational controller. It also keeps saturating per-source stall-cycle counters and a stall watchdog for debug and performance.

## Interface
- STAGES, 7, stall bus width; bit 0 = PC/IF, bit STAGES-1 = WB.
- NREQ, 8, number of stall request sources.
- REQ_MASK, NREQ*STAGES bits, field i (bits [i*STAGES +: STAGES]) = stall pattern applied when stallreq[i]=1.
- BLOCK_MASK, NREQ bits, bit i = 1: source i blocks redirect issue while asserted.
- FLUSH_LEN, 1, flush pulse length in cycles (1..15).
- TIMEOUT, 1024, consecutive stall cycles before watchdog trips.
- CNT_WD, 32, counter width.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- stallreq  in  NREQ  per-source stall requests, level.
- excp_valid  in  1  redirect request (exception or eret), single-cycle pulse.
- excp_pc  in  32  redirect target, sampled with excp_valid.
- rd_sel  in  $clog2(NREQ)  counter select.
- flush  out  1  flush all stages, registered.
- new_pc  out  32  redirect target, valid while flush=1, else 0.
- stall  out  STAGES  per-stage stall bus.
- pend  out  1  redirect held pending.
- excp_drop  out  1  sticky: a redirect arrived while one was pending or flushing.
- stall_timeout  out  1  sticky watchdog flag.
- rd_data  out  CNT_WD  counter[rd_sel], combinational.

## Operation
- blocked = |(stallreq & BLOCK_MASK).
- stall = 0 while rst or flush; otherwise OR over i of (stallreq[i] ? REQ_MASK field i : 0). Combinational.
- FSM states IDLE, PEND, FLUSH; reset to IDLE.
- IDLE: excp_valid & ~blocked -> FLUSH, latch excp_pc, load flush counter with FLUSH_LEN. excp_valid & blocked -> PEND, latch excp_pc.
- PEND: ~blocked -> FLUSH with the latched pc, counter loaded with FLUSH_LEN. Otherwise stay in PEND.
- FLUSH: counter decrements each cycle; when it reaches 1 -> IDLE, or -> PEND if a redirect was captured during the flush.
- excp_valid in PEND, or in FLUSH with a capture already held: the new request is discarded and excp_drop is set. The first (oldest) redirect always wins.
- excp_valid in FLUSH with no capture held: capture excp_pc; it is issued after the current pulse, through PEND.
- flush=1 exactly while in FLUSH; new_pc = latched pc in FLUSH, else 0. pend=1 in PEND.
- Counters: counter[i] increments when stallreq[i] & ~flush, saturating at all-ones.
- Watchdog: consecutive-cycle counter of (|stall). It clears whenever stall=0, and sets stall_timeout when it reaches TIMEOUT. stall_timeout clears only on rst.
- Reset mid-operation: FSM, pending/captured pc, counters and sticky flags all cleared on the next edge.

## Timing
- Reset values: flush=0, new_pc=0, pend=0, excp_drop=0, stall_timeout=0, all counters 0; stall=0 while rst=1.
- Redirect latency, unblocked: excp_valid in cycle N -> flush=1 in cycles N+1 .. N+FLUSH_LEN.
- Redirect latency, blocked: flush rises the cycle after the first cycle in which blocked=0.
- A non-blocking stall (BLOCK_MASK bit 0) never delays flush.
- The stall bus is forced to 0 during every flush cycle.
- rd_data reflects counts up to the previous edge.

## Test plan
- Reset and unblocked redirect: rst high 2 cycles, then check all outputs are 0. Drive excp_valid with excp_pc=0xBFC00380, FLUSH_LEN=1 -> flush=1 and new_pc=0xBFC00380 for exactly one cycle, starting the next cycle.
- Blocked redirect: hold stallreq[cache] (blocking) for 5 cycles, pulse excp_valid in cycle 1 -> pend=1 for cycles 2..6, flush rises in the cycle after stallreq drops. stall is all-ones while the cache is held, 0 during the flush.
- Mask merge: REQ_MASK field for load = 7'b0000101, field for fifo = 7'b0000001; assert both -> stall=7'b0000101. Assert load alone -> stall=7'b0000101.
- Back-to-back redirects: FLUSH_LEN=3, excp A at N, excp B at N+1, excp C at N+2 -> A flushes for 3 cycles, then B issues, C is dropped and excp_drop=1.
- Counters and saturation: CNT_WD=4, hold stallreq[2] for 20 cycles -> counter[2]=15 (rd_sel=2); other counters stay 0.
- Watchdog: TIMEOUT=8, hold a stall for 8 cycles -> stall_timeout=1 and it stays 1 after the stall drops. rst -> 0.
